// File: rtl/demux2_pkg.sv
// Shared types and constants for the demux2_stream 1-to-2 stream demultiplexer.
package demux2_pkg;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

  localparam int CNT_W     = 8;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/demux2_slot.sv
// One-entry output holding register with valid/ready handshake; optional
// delivered-word counter when DEMUX2_CNT_EN is defined.
module demux2_slot
  import demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_load
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_t state;
  slot_state_t state_next;
  logic        drain;

  assign valid    = (state == SLOT_FULL);
  assign drain    = valid & ready;
  // A full slot that drains this cycle can take a new word without a bubble.
  assign can_load = (state == SLOT_EMPTY) | ready;

  // NOTE: default assigned first so every path drives state_next; no latch.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = SLOT_FULL;
    end else if (drain) begin
      state_next = SLOT_EMPTY;
    end
  end

  // NOTE: non-blocking assignments for all clocked state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the data register is reset too, so z*_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

`ifdef DEMUX2_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: routes each accepted word to z0 or z1
// by in_sel. Optional per-output delivered-word counters with DEMUX2_CNT_EN.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z0_data,
  output logic             z0_valid,
  input  logic             z0_ready,
  output logic [WIDTH-1:0] z1_data,
  output logic             z1_valid,
  input  logic             z1_ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic can_load0;
  logic can_load1;
  logic accept;
  logic load0;
  logic load1;

  // Ready depends only on the selected slot, never on in_valid; held low in reset.
  assign in_ready = rst_n & (in_sel ? can_load1 : can_load0);
  assign accept   = in_valid & in_ready;
  assign load0    = accept & ~in_sel;
  assign load1    = accept & in_sel;

  demux2_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load0),
    .load_data(in_data),
    .ready    (z0_ready),
    .valid    (z0_valid),
    .data     (z0_data),
    .can_load (can_load0)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt      (cnt0)
`endif
  );

  demux2_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load1),
    .load_data(in_data),
    .ready    (z1_ready),
    .valid    (z1_valid),
    .data     (z1_data),
    .can_load (can_load1)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt      (cnt1)
`endif
  );

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: per-output scoreboard queues plus
// directed checks for reset, routing, isolation, pass-through and counters.
module tb_demux2_stream;
  import demux2_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] z0_data;
  logic         z0_valid;
  logic         z0_ready;
  logic [W-1:0] z1_data;
  logic         z1_valid;
  logic         z1_ready;
`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  demux2_stream #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_sel  (in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .z0_data (z0_data),
    .z0_valid(z0_valid),
    .z0_ready(z0_ready),
    .z1_data (z1_data),
    .z1_valid(z1_valid),
    .z1_ready(z1_ready)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt0    (cnt0),
    .cnt1    (cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  int           m_cnt0 = 0;
  int           m_cnt1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: samples 1 ns before each rising edge, pops scoreboard on output
  // transfers, pushes on input transfers, and checks data stability under stall.
  logic         stall0 = 1'b0;
  logic         stall1 = 1'b0;
  logic [W-1:0] held0;
  logic [W-1:0] held1;

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      stall0 = 1'b0;
      stall1 = 1'b0;
    end else begin
      if (stall0) begin
        check("z0_hold_valid", 32'(z0_valid), 32'd1);
        check("z0_hold_data", 32'(z0_data), 32'(held0));
      end
      if (stall1) begin
        check("z1_hold_valid", 32'(z1_valid), 32'd1);
        check("z1_hold_data", 32'(z1_data), 32'(held1));
      end
      if (z0_valid && z0_ready) begin
        m_cnt0++;
        if (exp0.size() == 0) check("z0_unexpected", 32'd1, 32'd0);
        else check("z0_sb", 32'(z0_data), 32'(exp0.pop_front()));
      end
      if (z1_valid && z1_ready) begin
        m_cnt1++;
        if (exp1.size() == 0) check("z1_unexpected", 32'd1, 32'd0);
        else check("z1_sb", 32'(z1_data), 32'(exp1.pop_front()));
      end
      if (in_valid && in_ready) begin
        if (in_sel) exp1.push_back(in_data);
        else exp0.push_back(in_data);
      end
      stall0 = z0_valid & ~z0_ready;
      stall1 = z1_valid & ~z1_ready;
      held0  = z0_data;
      held1  = z1_data;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    z0_ready = 1'b0;
    z1_ready = 1'b0;
    tick();
    tick();

    check("rst_z0_valid", 32'(z0_valid), 32'd0);
    check("rst_z1_valid", 32'(z1_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_z0_data", 32'(z0_data), 32'd0);

    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Routing: 0xA5 to z0, then 0x3C to z1, both consumers ready.
    z0_ready = 1'b1;
    z1_ready = 1'b1;
    drive(8'hA5, 1'b0);
    check("rt_ready_a", 32'(in_ready), 32'd1);
    tick();
    check("rt_z0_valid", 32'(z0_valid), 32'd1);
    check("rt_z0_data", 32'(z0_data), 32'hA5);
    drive(8'h3C, 1'b1);
    check("rt_ready_b", 32'(in_ready), 32'd1);
    tick();
    check("rt_z1_valid", 32'(z1_valid), 32'd1);
    check("rt_z1_data", 32'(z1_data), 32'h3C);
    check("rt_z0_drained", 32'(z0_valid), 32'd0);
    idle();
    tick();
    check("rt_z1_drained", 32'(z1_valid), 32'd0);

    // Isolation: z0 stalled holding 0x11 must not block a word for z1.
    z0_ready = 1'b0;
    drive(8'h11, 1'b0);
    tick();
    check("iso_z0_data", 32'(z0_data), 32'h11);
    drive(8'h33, 1'b0);
    check("iso_block0", 32'(in_ready), 32'd0);
    tick();
    drive(8'h22, 1'b1);
    check("iso_pass1", 32'(in_ready), 32'd1);
    tick();
    check("iso_z1_valid", 32'(z1_valid), 32'd1);
    check("iso_z1_data", 32'(z1_data), 32'h22);
    check("iso_z0_keep", 32'(z0_data), 32'h11);
    idle();
    z0_ready = 1'b1;
    tick();
    tick();
    check("iso_z0_drained", 32'(z0_valid), 32'd0);

    // Pass-through: slot 1 full, then 10 back-to-back sel-1 words.
    z1_ready = 1'b0;
    drive(8'h40, 1'b1);
    tick();
    check("pt_full", 32'(z1_valid), 32'd1);
    z1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(8'(8'h50 + i), 1'b1);
      check("pt_ready", 32'(in_ready), 32'd1);
      tick();
      check("pt_valid", 32'(z1_valid), 32'd1);
      check("pt_data", 32'(z1_data), 32'(8'h50 + i));
    end
    idle();
    tick();
    check("pt_drained", 32'(z1_valid), 32'd0);

    // Mixed alternating traffic with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      z0_ready = 1'($urandom_range(0, 1));
      z1_ready = 1'($urandom_range(0, 1));
      drive(8'($urandom), 1'(i % 2));
      tick();
    end
    idle();
    z0_ready = 1'b1;
    z1_ready = 1'b1;
    tick();
    tick();

    // Mid-stream reset with both slots full.
    z0_ready = 1'b0;
    z1_ready = 1'b0;
    drive(8'h77, 1'b0);
    tick();
    drive(8'h88, 1'b1);
    tick();
    idle();
    check("mr_z0_full", 32'(z0_valid), 32'd1);
    check("mr_z1_full", 32'(z1_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_z0_valid", 32'(z0_valid), 32'd0);
    check("mr_z1_valid", 32'(z1_valid), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd0);
    check("mr_z1_data", 32'(z1_data), 32'd0);
`ifdef DEMUX2_CNT_EN
    check("mr_cnt0", 32'(cnt0), 32'd0);
    check("mr_cnt1", 32'(cnt1), 32'd0);
`endif
    exp0.delete();
    exp1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_release_ready", 32'(in_ready), 32'd1);
    z0_ready = 1'b1;
    z1_ready = 1'b1;

    // One word to z1, then 256 words to z0: cnt0 wraps to 0, cnt1 stays 1.
    drive(8'hC3, 1'b1);
    tick();
    for (int i = 0; i < 256; i++) begin
      drive(8'(i), 1'b0);
      tick();
    end
    idle();
    tick();
    tick();
`ifdef DEMUX2_CNT_EN
    check("cnt0_wrap", 32'(cnt0), 32'd0);
    check("cnt1_keep", 32'(cnt1), 32'd1);
    check("cnt0_model", 32'(cnt0), 32'(m_cnt0 % 256));
`endif
    check("m_cnt0_total", 32'(m_cnt0), 32'd256);

    begin : drain
      int budget = 20;
      while ((exp0.size() + exp1.size()) != 0 && budget > 0) begin
        tick();
        budget--;
      end
    end
    check("sb_drained", 32'(exp0.size() + exp1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
